uart_core: RTL and testbench

//  Full-duplex UART datapath: programmable baud-tick generator plus a frame

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_core_blocks.sv | 258 +++++++++++++++++++++++++
 rtl/uart_core.sv | 73 +++++++
 tb/tb_uart_core.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART datapath: default frame geometry and the
// state encodings of the transmit and receive FSMs.
package uart_pkg;

   localparam int SIZE_DATA_DEF   = 8;
   localparam int OVER_SAMPLE_DEF = 16;
   localparam int MID_SAMPLE_DEF  = 8;
   localparam int SIZE_BAUD_DEF   = 24;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_core_blocks.sv
// Building blocks of uart_core: baud tick generator, frame transmitter and
// frame receiver. All share one clock, one async active-low reset and the
// single baud tick produced by baud_generator.
//
// baud_generator
//   i_clk, i_rst_n   clock / async active-low reset
//   i_baud_rate      divisor; tick period = i_baud_rate+1 clocks
//   o_tick           one-clock pulse per baud period
module baud_generator #(
   parameter int SIZE_BAUD = 24
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [SIZE_BAUD-1:0] i_baud_rate,
   output logic                 o_tick
);

   logic [SIZE_BAUD-1:0] count_q;
   logic                 tick_q;

   // A divisor lowered below the running count is not caught here: the count
   // carries on to the all-ones wrap, so divisor changes land on a wrap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else if (count_q == i_baud_rate) begin
         count_q <= '0;
         tick_q  <= 1'b1;
      end else begin
         count_q <= count_q + 1'b1;
         tick_q  <= 1'b0;
      end
   end

   assign o_tick = tick_q;

endmodule

// transmitter
//   i_tick                  shared baud tick
//   i_tx_en, i_fifo_empty   frame start qualifiers, looked at only in IDLE
//   i_tx_data               byte captured at frame start
//   o_tx_serial             line out, idle high
//   o_tx_valid              high for the whole frame
//   o_tx_done               one-clock pulse at the end of the stop bit
//
//   state    | meaning
//   TX_IDLE  | line high, waiting for enable and a non-empty FIFO
//   TX_START | start bit (low) for OVER_SAMPLE ticks
//   TX_DATA  | data bits LSB first, OVER_SAMPLE ticks each
//   TX_STOP  | stop bit (high); done pulse on its last tick
module transmitter
   import uart_pkg::*;
#(
   parameter int SIZE_DATA   = SIZE_DATA_DEF,
   parameter int OVER_SAMPLE = OVER_SAMPLE_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_tick,
   input  logic                 i_tx_en,
   input  logic                 i_fifo_empty,
   input  logic [SIZE_DATA-1:0] i_tx_data,
   output logic                 o_tx_serial,
   output logic                 o_tx_done,
   output logic                 o_tx_valid
);

   localparam int TW = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
   localparam int BW = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;

   tx_state_e            state_q;
   logic [TW-1:0]        tick_cnt_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [SIZE_DATA-1:0] shift_q;
   logic                 serial_q;
   logic                 valid_q;
   logic                 done_q;
   logic                 last_tick;

   assign last_tick = i_tick && (tick_cnt_q == TW'(OVER_SAMPLE - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= TX_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         serial_q   <= 1'b1;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (i_tick && state_q != TX_IDLE) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
         end
         case (state_q)
            TX_IDLE: begin
               serial_q <= 1'b1;
               if (i_tx_en && !i_fifo_empty) begin
                  shift_q    <= i_tx_data;
                  valid_q    <= 1'b1;
                  serial_q   <= 1'b0;
                  tick_cnt_q <= '0;
                  state_q    <= TX_START;
               end
            end
            TX_START: begin
               if (last_tick) begin
                  bit_cnt_q <= '0;
                  serial_q  <= shift_q[0];
                  state_q   <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (last_tick) begin
                  if (bit_cnt_q == BW'(SIZE_DATA - 1)) begin
                     serial_q <= 1'b1;
                     state_q  <= TX_STOP;
                  end else begin
                     // Next bit is presented straight from the pre-shift value.
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     shift_q   <= shift_q >> 1;
                     serial_q  <= shift_q[1];
                  end
               end
            end
            TX_STOP: begin
               if (last_tick) begin
                  done_q  <= 1'b1;
                  valid_q <= 1'b0;
                  state_q <= TX_IDLE;
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign o_tx_serial = serial_q;
   assign o_tx_valid  = valid_q;
   assign o_tx_done   = done_q;

endmodule

// receiver
//   i_tick                 shared baud tick
//   i_rx_en, i_rx_valid    gate start-bit detection only
//   i_fifo_full            drop the byte at the stop bit when set
//   i_rx_serial            asynchronous line in (synchronised here)
//   o_rx_data              last accepted byte
//   o_rx_done              one-clock pulse when o_rx_data updates
//
//   state    | meaning
//   RX_IDLE  | waiting for a qualified low on the synchronised line
//   RX_START | counting to the start-bit centre; high there = glitch
//   RX_DATA  | sampling SIZE_DATA bits at OVER_SAMPLE-tick spacing
//   RX_STOP  | sampling the stop bit; deliver or drop the byte
module receiver
   import uart_pkg::*;
#(
   parameter int SIZE_DATA   = SIZE_DATA_DEF,
   parameter int OVER_SAMPLE = OVER_SAMPLE_DEF,
   parameter int MID_SAMPLE  = MID_SAMPLE_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_tick,
   input  logic                 i_rx_en,
   input  logic                 i_rx_valid,
   input  logic                 i_fifo_full,
   input  logic                 i_rx_serial,
   output logic [SIZE_DATA-1:0] o_rx_data,
   output logic                 o_rx_done
);

   localparam int TW = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
   localparam int BW = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;

   rx_state_e            state_q;
   logic [1:0]           sync_q;
   logic [TW-1:0]        tick_cnt_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [SIZE_DATA-1:0] shift_q;
   logic [SIZE_DATA-1:0] data_q;
   logic                 done_q;
   logic                 line;
   logic                 last_tick;

   assign line      = sync_q[1];
   assign last_tick = i_tick && (tick_cnt_q == TW'(OVER_SAMPLE - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q     <= 2'b11;
         state_q    <= RX_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], i_rx_serial};
         done_q <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (i_rx_en && i_rx_valid && !line) begin
                  tick_cnt_q <= '0;
                  state_q    <= RX_START;
               end
            end
            RX_START: begin
               if (i_tick) begin
                  if (tick_cnt_q == TW'(MID_SAMPLE - 1)) begin
                     // Restart the count so later samples sit at bit centres.
                     tick_cnt_q <= '0;
                     bit_cnt_q  <= '0;
                     state_q    <= line ? RX_IDLE : RX_DATA;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
            end
            RX_DATA: begin
               if (i_tick) begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
               if (last_tick) begin
                  shift_q <= {line, shift_q[SIZE_DATA-1:1]};
                  if (bit_cnt_q == BW'(SIZE_DATA - 1)) begin
                     state_q <= RX_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            RX_STOP: begin
               if (i_tick) begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
               if (last_tick) begin
                  if (line && !i_fifo_full) begin
                     data_q <= shift_q;
                     done_q <= 1'b1;
                  end
                  state_q <= RX_IDLE;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign o_rx_data = data_q;
   assign o_rx_done = done_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART datapath between the TX/RX FIFOs and the serial pins.
// Only wiring: one baud generator whose tick is shared by both directions.
//
// Ports
//   i_clk, i_rst_n                  clock / async active-low reset
//   i_baud_rate                     tick period = i_baud_rate+1 clocks
//   i_tx_en, i_fifo_empty, i_tx_data, o_tx_serial, o_tx_done, o_tx_valid
//                                   transmit side
//   i_rx_en, i_fifo_full, i_rx_serial, i_rx_valid, o_rx_data, o_rx_done
//                                   receive side
module uart_core
   import uart_pkg::*;
#(
   parameter int SIZE_DATA   = SIZE_DATA_DEF,
   parameter int OVER_SAMPLE = OVER_SAMPLE_DEF,
   parameter int MID_SAMPLE  = MID_SAMPLE_DEF,
   parameter int SIZE_BAUD   = SIZE_BAUD_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [SIZE_BAUD-1:0] i_baud_rate,
   input  logic                 i_tx_en,
   input  logic                 i_fifo_empty,
   input  logic [SIZE_DATA-1:0] i_tx_data,
   output logic                 o_tx_serial,
   output logic                 o_tx_done,
   output logic                 o_tx_valid,
   input  logic                 i_rx_en,
   input  logic                 i_fifo_full,
   input  logic                 i_rx_serial,
   input  logic                 i_rx_valid,
   output logic [SIZE_DATA-1:0] o_rx_data,
   output logic                 o_rx_done
);

   logic tick;

   baud_generator #(.SIZE_BAUD(SIZE_BAUD)) u_baud (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_baud_rate (i_baud_rate),
      .o_tick      (tick)
   );

   transmitter #(.SIZE_DATA(SIZE_DATA), .OVER_SAMPLE(OVER_SAMPLE)) u_tx (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_tick       (tick),
      .i_tx_en      (i_tx_en),
      .i_fifo_empty (i_fifo_empty),
      .i_tx_data    (i_tx_data),
      .o_tx_serial  (o_tx_serial),
      .o_tx_done    (o_tx_done),
      .o_tx_valid   (o_tx_valid)
   );

   receiver #(
      .SIZE_DATA   (SIZE_DATA),
      .OVER_SAMPLE (OVER_SAMPLE),
      .MID_SAMPLE  (MID_SAMPLE)
   ) u_rx (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_tick      (tick),
      .i_rx_en     (i_rx_en),
      .i_rx_valid  (i_rx_valid),
      .i_fifo_full (i_fifo_full),
      .i_rx_serial (i_rx_serial),
      .o_rx_data   (o_rx_data),
      .o_rx_done   (o_rx_done)
   );

endmodule

// File: tb/tb_uart_core.sv
// Loopback bench for uart_core. The TX line is decoded by an independent
// bit-centre sampler; RX bytes are checked against a queue of bytes the
// stimulus expects to be delivered. The RX input can be taken over by the
// bench to bit-bang glitches, framing errors and gated frames.
module tb_uart_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] baud_rate;
   logic        tx_en, fifo_empty, rx_en, fifo_full;
   logic [7:0]  tx_data;
   logic        tx_serial, tx_done, tx_valid, rx_done;
   logic [7:0]  rx_data;
   logic        rx_serial, rx_valid;
   logic        ovr_en, ovr_val, ovr_valid;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   int          T        = 1;
   int          frames_sent = 0;
   int          tx_done_cnt = 0;
   logic [7:0]  last_rx  = 8'h00;
   logic [7:0]  tx_exp_q[$];
   logic [7:0]  rx_exp_q[$];

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rx_serial = ovr_en ? ovr_val   : tx_serial;
   assign rx_valid  = ovr_en ? ovr_valid : tx_valid;

   uart_core dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_baud_rate  (baud_rate),
      .i_tx_en      (tx_en),
      .i_fifo_empty (fifo_empty),
      .i_tx_data    (tx_data),
      .o_tx_serial  (tx_serial),
      .o_tx_done    (tx_done),
      .o_tx_valid   (tx_valid),
      .i_rx_en      (rx_en),
      .i_fifo_full  (fifo_full),
      .i_rx_serial  (rx_serial),
      .i_rx_valid   (rx_valid),
      .o_rx_data    (rx_data),
      .o_rx_done    (rx_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // TX line decoder: samples each bit at its nominal centre from the start edge.
   initial begin : tx_monitor
      int unsigned t0, target, d;
      logic [7:0]  b, e;
      logic        s;
      bit          got;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx_serial === 1'b0) begin
            t0 = cyc;
            b  = 8'h00;
            for (int k = 0; k < 10; k++) begin
               target = t0 + 8*T + 16*T*k;
               while (cyc != target) @(negedge clk);
               s = tx_serial;
               if (k == 0) check("tx_start_bit", {31'd0, s}, 32'd0);
               else if (k == 9) check("tx_stop_bit", {31'd0, s}, 32'd1);
               else b[k-1] = s;
            end
            n_checks++;
            if (tx_exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL tx_unexpected_frame: got 0x%0h, expected no frame", b);
            end else begin
               e = tx_exp_q.pop_front();
               n_checks--;
               check("tx_byte", {24'd0, b}, {24'd0, e});
            end
            got = 1'b0;
            while (cyc - t0 <= 160*T + 2) begin
               if (tx_done) begin got = 1'b1; break; end
               @(negedge clk);
            end
            d = cyc - t0;
            n_checks++;
            if (!got || d < 159*T + 1 || d > 160*T) begin
               n_fail++;
               $display("FAIL tx_done_timing: got %0d clocks (seen=%0d), expected %0d..%0d",
                        d, got, 159*T + 1, 160*T);
            end
         end
      end
   end

   initial begin : tx_done_counter
      forever begin
         @(negedge clk);
         if (tx_done === 1'b1) tx_done_cnt++;
      end
   end

   initial begin : rx_monitor
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && rx_done === 1'b1) begin
            if (rx_exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rx_unexpected_done: got 0x%0h, expected no delivery", rx_data);
            end else begin
               e = rx_exp_q.pop_front();
               check("rx_byte", {24'd0, rx_data}, {24'd0, e});
               last_rx = e;
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input bit full);
      bit ok;
      tx_data    = d;
      fifo_full  = full;
      fifo_empty = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (tx_valid) begin ok = 1'b1; break; end
      end
      check("tx_frame_start", {31'd0, ok}, 32'd1);
      if (ok) begin
         tx_exp_q.push_back(d);
         if (!full) rx_exp_q.push_back(d);
         frames_sent++;
         tx_data = 8'($urandom);
         ok = 1'b0;
         for (int k = 0; k < 170*T; k++) begin
            @(negedge clk);
            if (tx_done) begin ok = 1'b1; break; end
         end
         check("tx_done_seen", {31'd0, ok}, 32'd1);
      end
   endtask

   task automatic bitbang(input logic [7:0] d, input logic stop);
      ovr_valid = 1'b1;
      ovr_val   = 1'b0;
      repeat (16*T) @(negedge clk);
      ovr_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ovr_val = d[i];
         repeat (16*T) @(negedge clk);
      end
      ovr_val = stop;
      repeat (16*T) @(negedge clk);
      ovr_val = 1'b1;
      repeat (16*T) @(negedge clk);
      ovr_valid = 1'b1;
   endtask

   task automatic run_loopback(input int n, input bit directed);
      logic [7:0] d;
      bit         full;
      ovr_en = 1'b0;
      tx_en  = 1'b1;
      rx_en  = 1'b1;
      for (int i = 0; i < n; i++) begin
         d    = (directed && i == 0) ? 8'h29 : 8'($urandom);
         full = (directed && i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
         send_frame(d, full);
      end
      fifo_empty = 1'b1;
      fifo_full  = 1'b0;
      repeat (4) @(negedge clk);
      check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_rx});
      check("rx_pending_loopback", rx_exp_q.size(), 32'd0);
   endtask

   task automatic run_idle_checks();
      int done_before;
      done_before = tx_done_cnt;
      fifo_empty = 1'b1;
      tx_en      = 1'b1;
      repeat (40*T) @(negedge clk);
      check("tx_empty_line", {31'd0, tx_serial}, 32'd1);
      check("tx_empty_valid", {31'd0, tx_valid}, 32'd0);
      tx_en      = 1'b0;
      fifo_empty = 1'b0;
      repeat (40*T) @(negedge clk);
      check("tx_disabled_line", {31'd0, tx_serial}, 32'd1);
      check("tx_disabled_valid", {31'd0, tx_valid}, 32'd0);
      fifo_empty = 1'b1;
      check("tx_idle_no_done", tx_done_cnt, done_before);
   endtask

   task automatic run_rx_bitbang();
      logic [7:0] d;
      ovr_en    = 1'b1;
      ovr_val   = 1'b1;
      ovr_valid = 1'b1;
      rx_en     = 1'b1;
      repeat (4*T) @(negedge clk);
      // Short low pulse: rejected at the start-bit centre.
      ovr_val = 1'b0;
      repeat (3*T) @(negedge clk);
      ovr_val = 1'b1;
      repeat (40*T) @(negedge clk);
      // Framing error: stop bit held low.
      bitbang(8'($urandom), 1'b0);
      check("rx_framing_hold", {24'd0, rx_data}, {24'd0, last_rx});
      // Receiver disabled: no start detection at all.
      rx_en = 1'b0;
      bitbang(8'($urandom), 1'b1);
      rx_en = 1'b1;
      // Valid frame with the qualifier dropped after the start bit.
      d = 8'($urandom);
      rx_exp_q.push_back(d);
      bitbang(d, 1'b1);
      repeat (20*T) @(negedge clk);
      check("rx_pending_bitbang", rx_exp_q.size(), 32'd0);
      ovr_en = 1'b0;
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int bauds[4] = '{0, 1, 2, 5};
      rst_n      = 1'b0;
      baud_rate  = 24'd0;
      tx_en      = 1'b0;
      fifo_empty = 1'b1;
      tx_data    = 8'h00;
      rx_en      = 1'b0;
      fifo_full  = 1'b0;
      ovr_en     = 1'b0;
      ovr_val    = 1'b1;
      ovr_valid  = 1'b0;
      #25;
      check("rst_tx_serial", {31'd0, tx_serial}, 32'd1);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_done", {31'd0, tx_done}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_rx_done", {31'd0, rx_done}, 32'd0);
      #15;
      rst_n = 1'b1;
      // Divisor only ever grows, so the running count never overshoots it.
      for (int i = 0; i < 4; i++) begin
         baud_rate = 24'(bauds[i]);
         T = bauds[i] + 1;
         repeat (2*T) @(negedge clk);
         run_loopback(5, i == 0);
         run_idle_checks();
         run_rx_bitbang();
      end
      repeat (50) @(negedge clk);
      check("tx_queue_drained", tx_exp_q.size(), 32'd0);
      check("tx_done_total", tx_done_cnt, frames_sent);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
